// File: rtl/alu_pkg.sv
// alu_seq shared types: modes, opcodes, FSM states.
// is_legal() flags opcodes outside the defined set.
package alu_pkg;

  typedef enum logic {
    MEM_BR = 1'b0,
    ARITH  = 1'b1
  } mode_e;

  typedef enum logic [3:0] {
    OP_ADDR = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2
  } memop_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INV  = 4'd2,
    OP_SHL  = 4'd3,
    OP_SHR  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTS = 4'd8,
    OP_MUL  = 4'd9,
    OP_SRA  = 4'd10
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic is_legal(
    input logic       mode,
    input logic [3:0] op
  );
    return (mode == ARITH) ? (op <= 4'd10)
                           : (op <= 4'd2);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master drives operations, slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH    = 16,
  parameter int OFFSET_W = 6
);
  logic                start;
  logic                ready;
  logic                abort;
  logic                aluMode;
  logic [3:0]          op;
  logic [WIDTH-1:0]    rd1;
  logic [WIDTH-1:0]    rd2;
  logic [OFFSET_W-1:0] offset;
  logic [WIDTH-1:0]    result;
  logic [WIDTH-1:0]    result_hi;
  logic                done;
  logic                branch_taken;
  logic                illegal;

  modport master (
    output start, abort, aluMode, op,
    output rd1, rd2, offset,
    input  ready, result, result_hi,
    input  done, branch_taken, illegal
  );

  modport slave (
    input  start, abort, aluMode, op,
    input  rd1, rd2, offset,
    output ready, result, result_hi,
    output done, branch_taken, illegal
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add multiplier, one iteration per cycle.
// prod/fin show the final product during the last step.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetALU_n,
  input  logic               load,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // one shift-add step: add multiplicand on lsb, shift right
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  assign busy = (cnt != '0);
  assign fin  = busy && (cnt == CW'(1)) && !abort;
  assign prod = acc_nxt;

  // operand load, iteration and cancel
  always_ff @(posedge clk or negedge resetALU_n) begin
    if (!resetALU_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= CW'(WIDTH);
    end else if (busy) begin
      if (abort) begin
        cnt <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute ALU: single-cycle ops plus
// an iterative multiply behind ready back-pressure.
module alu_seq #(
  parameter int WIDTH    = 16,
  parameter int OFFSET_W = 6
) (
  input logic      clk,
  input logic      resetALU_n,
  alu_seq_if.slave bus
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  state_e state, state_nxt;

  logic               accept;
  logic               legal;
  logic               is_mul;
  logic               big;
  logic [WIDTH-1:0]   a, b;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_br;
  logic               mul_busy;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_p;

  logic [WIDTH-1:0] res_q, hi_q;
  logic             done_q, br_q, ill_q;
  logic [WIDTH-1:0] res_d, hi_d;
  logic             done_d, br_d, ill_d;

  assign a      = bus.rd1;
  assign b      = bus.rd2;
  assign big    = (b >= WLIM);
  assign accept = bus.start && bus.ready;
  assign legal  = is_legal(bus.aluMode, bus.op);
  assign is_mul = (bus.aluMode == ARITH)
               && (bus.op == OP_MUL);

  assign bus.ready        = (state == IDLE);
  assign bus.result       = res_q;
  assign bus.result_hi    = hi_q;
  assign bus.done         = done_q;
  assign bus.branch_taken = br_q;
  assign bus.illegal      = ill_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .resetALU_n (resetALU_n),
    .load       (accept && is_mul),
    .abort      (bus.abort),
    .a          (a),
    .b          (b),
    .busy       (mul_busy),
    .fin        (mul_fin),
    .prod       (mul_p)
  );

  // single-cycle datapath on the live operands
  always_comb begin
    alu_r  = res_q;
    alu_br = 1'b0;
    if (bus.aluMode == ARITH) begin
      unique case (bus.op)
        OP_ADD:  alu_r = a + b;
        OP_SUB:  alu_r = a - b;
        OP_INV:  alu_r = ~a;
        OP_SHL:  alu_r = big ? '0 : (a << b);
        OP_SHR:  alu_r = big ? '0 : (a >> b);
        OP_SRA:  alu_r = big ? {WIDTH{a[WIDTH-1]}}
                             : WIDTH'($signed(a) >>> b);
        OP_AND:  alu_r = a & b;
        OP_OR:   alu_r = a | b;
        OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, a < b};
        OP_SLTS: alu_r = {{(WIDTH-1){1'b0}},
                          $signed(a) < $signed(b)};
        default: alu_r = res_q;
      endcase
    end else begin
      unique case (bus.op)
        OP_ADDR: alu_r  = a + {{(WIDTH-OFFSET_W){1'b0}},
                               bus.offset};
        OP_BEQ:  alu_br = (a == b);
        OP_BNE:  alu_br = (a != b);
        default: alu_br = 1'b0;
      endcase
    end
  end

  // next state and next output register values
  always_comb begin
    state_nxt = state;
    res_d     = res_q;
    hi_d      = hi_q;
    done_d    = 1'b0;
    br_d      = 1'b0;
    ill_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            !legal: begin
              done_d = 1'b1;
              ill_d  = 1'b1;
            end
            is_mul: state_nxt = MUL;
            default: begin
              done_d = 1'b1;
              br_d   = alu_br;
              res_d  = alu_r;
              hi_d   = '0;
            end
          endcase
        end
      end
      MUL: begin
        if (bus.abort || mul_fin || !mul_busy) begin
          state_nxt = IDLE;
        end
        if (mul_fin) begin
          done_d = 1'b1;
          res_d  = mul_p[WIDTH-1:0];
          hi_d   = mul_p[2*WIDTH-1:WIDTH];
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge resetALU_n) begin
    if (!resetALU_n) begin
      state  <= IDLE;
      res_q  <= '0;
      hi_q   <= '0;
      done_q <= 1'b0;
      br_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      res_q  <= res_d;
      hi_q   <= hi_d;
      done_q <= done_d;
      br_q   <= br_d;
      ill_q  <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// alu_seq bench: WIDTH=16 and WIDTH=32 instances driven
// in turn, checked against an arithmetic reference model.
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit          sel   = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode  = 1'b0;
  logic [3:0]  op    = '0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [5:0]  off   = '0;

  alu_seq_if #(.WIDTH(16), .OFFSET_W(6)) b16 ();
  alu_seq_if #(.WIDTH(32), .OFFSET_W(6)) b32 ();

  assign b16.start   = start & ~sel;
  assign b16.abort   = abort;
  assign b16.aluMode = mode;
  assign b16.op      = op;
  assign b16.rd1     = a[15:0];
  assign b16.rd2     = b[15:0];
  assign b16.offset  = off;

  assign b32.start   = start & sel;
  assign b32.abort   = abort;
  assign b32.aluMode = mode;
  assign b32.op      = op;
  assign b32.rd1     = a;
  assign b32.rd2     = b;
  assign b32.offset  = off;

  alu_seq #(.WIDTH(16), .OFFSET_W(6)) u16 (
    .clk        (clk),
    .resetALU_n (rst_n),
    .bus        (b16)
  );

  alu_seq #(.WIDTH(32), .OFFSET_W(6)) u32 (
    .clk        (clk),
    .resetALU_n (rst_n),
    .bus        (b32)
  );

  logic        o_ready, o_done, o_br, o_ill;
  logic [31:0] o_res, o_hi;
  assign o_ready = sel ? b32.ready : b16.ready;
  assign o_done  = sel ? b32.done : b16.done;
  assign o_br    = sel ? b32.branch_taken : b16.branch_taken;
  assign o_ill   = sel ? b32.illegal : b16.illegal;
  assign o_res   = sel ? b32.result : {16'h0, b16.result};
  assign o_hi    = sel ? b32.result_hi : {16'h0, b16.result_hi};

  int          w      = 16;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mres   = '0;
  logic [63:0] mhi    = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s w=%0d got %0h exp %0h",
               tag, w, got, exp);
    end
  endtask

  task automatic model(input bit m, input logic [3:0] o,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [5:0] f,
                       output bit legal, output bit mul,
                       output bit br,
                       output logic [63:0] r,
                       output logic [63:0] h);
    logic [63:0] mask, p;
    longint      sx, sy;
    mask  = (64'd1 << w) - 64'd1;
    sx    = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy    = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    legal = 1'b1;
    mul   = 1'b0;
    br    = 1'b0;
    r     = mres;
    h     = '0;
    if (!m) begin
      case (o)
        4'd0: r = (x + 64'(f)) & mask;
        4'd1: br = (x == y);
        4'd2: br = (x != y);
        default: legal = 1'b0;
      endcase
    end else begin
      case (o)
        4'd0: r = (x + y) & mask;
        4'd1: r = (x - y) & mask;
        4'd2: r = ~x & mask;
        4'd3: r = (y >= 64'(w)) ? '0 : (x << y) & mask;
        4'd4: r = (y >= 64'(w)) ? '0 : (x >> y);
        4'd5: r = x & y;
        4'd6: r = x | y;
        4'd7: r = (x < y) ? 64'd1 : 64'd0;
        4'd8: r = (sx < sy) ? 64'd1 : 64'd0;
        4'd9: begin
          p   = x * y;
          r   = p & mask;
          h   = p >> w;
          mul = 1'b1;
        end
        4'd10: r = (y >= 64'(w)) ? (x[w-1] ? mask : '0)
                                 : (64'(sx >>> y) & mask);
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      r = mres;
      h = mhi;
    end
  endtask

  task automatic do_op(input bit m, input logic [3:0] o,
                       input logic [63:0] xi, input logic [63:0] yi,
                       input logic [5:0] f, input int abk);
    bit          legal, mul, br;
    logic [63:0] r, h, mask, x, y;
    int          k;
    mask = (64'd1 << w) - 64'd1;
    x    = xi & mask;
    y    = yi & mask;
    model(m, o, x, y, f, legal, mul, br, r, h);
    chk("ready_in", 64'(o_ready), 64'd1);
    mode  = m;
    op    = o;
    a     = x[31:0];
    b     = y[31:0];
    off   = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (!mul) begin
      chk("done", 64'(o_done), 64'd1);
      chk("illegal", 64'(o_ill), 64'(!legal));
      chk("branch", 64'(o_br), 64'(br));
      chk("result", 64'(o_res), r);
      chk("result_hi", 64'(o_hi), h);
      chk("ready_out", 64'(o_ready), 64'd1);
      mres = r;
      mhi  = h;
      return;
    end
    chk("mul_busy", 64'(o_ready), 64'd0);
    k = 1;
    while (k <= w + 4 && !o_done && k != abk) begin
      start = k[0] && (k < w - 1);
      a     = $urandom;
      b     = $urandom;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    if (abk != 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done", 64'(o_done), 64'd0);
      chk("abort_ready", 64'(o_ready), 64'd1);
      chk("abort_res", 64'(o_res), mres);
      chk("abort_hi", 64'(o_hi), mhi);
      return;
    end
    chk("mul_latency", 64'(k), 64'(w + 1));
    chk("mul_done", 64'(o_done), 64'd1);
    chk("mul_res", 64'(o_res), r);
    chk("mul_hi", 64'(o_hi), h);
    chk("mul_ready", 64'(o_ready), 64'd1);
    chk("mul_ill", 64'(o_ill), 64'd0);
    mres = r;
    mhi  = h;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("done_pulse", 64'(o_done), 64'd0);
    chk("br_pulse", 64'(o_br), 64'd0);
    chk("ill_pulse", 64'(o_ill), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mres  = '0;
    mhi   = '0;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_result", 64'(o_res), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_br", 64'(o_br), 64'd0);
    chk("rst_ill", 64'(o_ill), 64'd0);
  endtask

  task automatic reset_mid_mul();
    int n;
    n     = 0;
    mode  = 1'b1;
    op    = 4'd9;
    a     = 32'h1234;
    b     = 32'h0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", 64'(o_res), 64'd0);
    chk("mid_rst_hi", 64'(o_hi), 64'd0);
    chk("mid_rst_done", 64'(o_done), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    mres = '0;
    mhi  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (w + 3) begin
      @(negedge clk);
      if (o_done) n++;
    end
    chk("mid_rst_no_done", 64'(n), 64'd0);
  endtask

  initial begin
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 1);
      w   = (pass == 1) ? 32 : 16;
      do_reset();
      do_op(1'b1, 4'd0, 64'h7FFF, 64'h2, 6'h0, 0);
      idle_chk();
      do_op(1'b0, 4'd0, 64'hFFF0, 64'h0, 6'h3F, 0);
      do_op(1'b0, 4'd1, 64'd5, 64'd5, 6'h0, 0);
      idle_chk();
      do_op(1'b0, 4'd2, 64'd5, 64'd5, 6'h0, 0);
      do_op(1'b1, 4'd9, 64'h1234, 64'h10, 6'h0, 0);
      idle_chk();
      do_op(1'b1, 4'd3, 64'h1, 64'(w), 6'h0, 0);
      do_op(1'b1, 4'd10, 64'd1 << (w - 1), 64'(w + 4), 6'h0, 0);
      do_op(1'b1, 4'd8, '1, 64'd1, 6'h0, 0);
      do_op(1'b1, 4'd7, '1, 64'd1, 6'h0, 0);
      do_op(1'b1, 4'd9, 64'hABCD, 64'h77, 6'h0, 5);
      do_op(1'b1, 4'd1, 64'd3, 64'd5, 6'h0, 0);
      do_op(1'b1, 4'd9, 64'hBEEF, 64'h1F3, 6'h0, w);
      abort = 1'b1;
      do_op(1'b1, 4'd0, 64'h11, 64'h22, 6'h0, 0);
      abort = 1'b1;
      do_op(1'b1, 4'd9, '1, '1, 6'h0, 0);
      reset_mid_mul();
      do_op(1'b1, 4'd0, 64'h11, 64'h22, 6'h0, 0);
      do_op(1'b1, 4'd12, 64'h5, 64'h6, 6'h0, 0);
      idle_chk();
      do_op(1'b0, 4'd5, 64'h5, 64'h6, 6'h0, 0);
      repeat (60) begin
        bit          m;
        logic [3:0]  o;
        logic [63:0] x, y;
        int          ab;
        m = 1'($urandom_range(0, 1));
        o = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) begin
          m = 1'b1;
          o = 4'd9;
        end
        x = {$urandom, $urandom};
        y = ($urandom_range(0, 1) == 1)
          ? 64'($urandom_range(0, w + 3))
          : {$urandom, $urandom};
        if (!m && $urandom_range(0, 3) == 0) y = x;
        ab = (m && o == 4'd9 && $urandom_range(0, 3) == 0)
           ? int'($urandom_range(1, w)) : 0;
        abort = 1'($urandom_range(0, 1));
        do_op(m, o, x, y, 6'($urandom), ab);
        if ($urandom_range(0, 1) == 1) idle_chk();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-shot execute ALU. It accepts one operation per `start`/`ready` handshake and registers its result. Most operations complete in one cycle. Multiply is an iterative multi-cycle shift-add, so the unit presents `ready` back-pressure to the control FSM. Done and branch outcome are reported as clean one-cycle pulses that clear on their own, which removes the separate ALU reset strobe.

## Interface
- `WIDTH`, 16: operand and result width; must be at least 4.
- `OFFSET_W`, 6: width of the immediate offset; must be less than `WIDTH`.
- `clk` in 1: the single clock; every flop is posedge.
- `resetALU_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request; accepted on a posedge where `start && ready`.
- `ready` out 1: unit can accept an operation; high exactly when the FSM is in IDLE.
- `abort` in 1: synchronous cancel of an in-flight multiply.
- `aluMode` in 1: 0 selects memory/branch ops, 1 selects arithmetic ops.
- `op` in 4: operation code; see Operation.
- `rd1`, `rd2` in `WIDTH`: operands, sampled only at acceptance.
- `offset` in `OFFSET_W`: immediate, sampled only at acceptance.
- `result` out `WIDTH`: registered result; holds until the next completing op.
- `result_hi` out `WIDTH`: upper half of the product for MUL; 0 for all other ops.
- `done` out 1: one-cycle completion pulse.
- `branch_taken` out 1: valid only while `done`=1; otherwise 0.
- `illegal` out 1: one-cycle pulse coincident with `done` for an unknown op.

## Operation
- **aluMode=0 opcodes**
  - 0 ADDR: `result = rd1 + zero-extended offset`, mod 2^WIDTH.
  - 1 BEQ: `branch_taken = (rd1 == rd2)`.
  - 2 BNE: `branch_taken = (rd1 != rd2)`.
  - Branches leave `result` unchanged.
- **aluMode=1 opcodes**
  - 0 ADD, 1 SUB: wrap mod 2^WIDTH.
  - 2 INV: `~rd1`.
  - 3 SHL, 4 SHR: logical shifts. Shift amount is the full `rd2`; if `rd2 >= WIDTH` the result is 0.
  - 10 SRA: arithmetic right shift. If `rd2 >= WIDTH` the result is all copies of `rd1[WIDTH-1]`.
  - 5 AND, 6 OR.
  - 7 SLT: unsigned compare, result 1 or 0.
  - 8 SLTS: two's-complement compare, result 1 or 0.
  - 9 MUL: unsigned product. Low half goes to `result`, high half to `result_hi`.
- **Illegal ops**: any other code (mode 0 op 3–15, mode 1 op 11–15).
  - Completes in one cycle with `done`=1 and `illegal`=1.
  - `result`, `result_hi` unchanged; `branch_taken`=0.
- **FSM**: IDLE → MUL on acceptance of MUL. IDLE → IDLE on acceptance of any other op. MUL → IDLE after `WIDTH` iterations or on `abort`.
- **Multiplier**: radix-2 shift-add with a 2·`WIDTH` accumulator and a `$clog2(WIDTH)+1`-bit iteration counter. Counter is loaded at acceptance and decremented once per cycle.
- **Abort**: while in MUL, returns to IDLE at the next edge. No `done` pulse; `result` and `result_hi` keep their prior values. `abort` in IDLE has no effect.
- **`start` while `ready`=0**: ignored, not queued.

## Timing
- **Reset values**: `result`=0, `result_hi`=0, `done`=0, `branch_taken`=0, `illegal`=0, FSM=IDLE, so `ready`=1.
- **Single-cycle ops**: accepted at edge N; `result`, `done` and flags are visible in the cycle after edge N (latency 1).
- **MUL**: accepted at edge N; `ready`=0 from after edge N; `done`=1 after edge N+`WIDTH`. `ready` returns to 1 in that same cycle.
- **Back-to-back**: an op may be accepted in the same cycle `done` is high. No bubble is required.
- **Pulse width**: `done`, `branch_taken` and `illegal` are high for exactly one cycle per completed op.
- **Reset mid-MUL**: asynchronous return to IDLE with all outputs at reset values. No `done` follows.
- **Abort and final iteration in the same cycle**: abort wins; no `done`.

## Structure
- **`alu_pkg`**
  - `mode_e` (MEM_BR, ARITH).
  - `op_e` with the codes above.
  - `state_e` (IDLE, MUL).
  - Function `is_legal(mode, op)`.
- **`alu_mul_seq`** sub-module: the iterative multiplier.
  - Inputs: `load`, `abort`, operands.
  - Outputs: `busy`, `fin` pulse, 2·`WIDTH` product.
- **`alu_seq` top**: handshake, FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset, then `aluMode`=1, op ADD, 0x7FFF + 0x0002 → `result`=0x8001 and one `done` pulse one cycle later; `ready` stays 1.
- `aluMode`=0, ADDR, `rd1`=0xFFF0, `offset`=6'h3F → `result`=0x002F. Then BEQ with 5,5 → `done`=1, `branch_taken`=1, `result` still 0x002F.
- MUL 0x1234 × 0x0010, `WIDTH`=16 → `ready`=0 for 16 cycles, then `result`=0x2340, `result_hi`=0x0001, `done` pulse. `start` pulses during busy are ignored.
- SHL with `rd2`=16 → 0. SRA of 0x8000 by 20 → 0xFFFF. SLTS 0xFFFF vs 0x0001 → 1; SLT on the same operands → 0.
- MUL started, `abort` at iteration 5 → no `done`, `result` unchanged, `ready`=1 next cycle. Then SUB 3−5 → 0xFFFE.
- `resetALU_n` low mid-MUL → all outputs 0 immediately. Mode 1 op 12 → `done`=1, `illegal`=1, `result` unchanged. Repeat with `WIDTH`=32.
